// File: rtl/sonar_frame_rx_pkg.sv
// Shared constants, state encodings and character helpers for the sonar frame receiver.
package sonar_frame_rx_pkg;

    // 50 MHz system clock, 115200 baud
    localparam int BAUD_DIV_DEFAULT = 434;

    localparam logic [6:0] ASCII_VIRGULA = 7'h2C;
    localparam logic [6:0] ASCII_HASH    = 7'h23;
    localparam logic [6:0] ASCII_ZERO    = 7'h30;

    // Parser position inside "DDD,DDD#"; RESYNC waits for a good '#'
    typedef enum logic [3:0] {
        ST_A2     = 4'd0,
        ST_A1     = 4'd1,
        ST_A0     = 4'd2,
        ST_VIRG   = 4'd3,
        ST_D2     = 4'd4,
        ST_D1     = 4'd5,
        ST_D0     = 4'd6,
        ST_FIM    = 4'd7,
        ST_RESYNC = 4'd8
    } parser_state_t;

    // Serial character receiver phases
    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    function automatic logic is_digit(input logic [6:0] c);
        return (c >= ASCII_ZERO) && (c <= ASCII_ZERO + 7'd9);
    endfunction

endpackage

// File: rtl/sonar_frame_rx_rx_serial.sv
// 7O1 character receiver: start, 7 data bits LSB first, odd parity, stop.
// pronto_rx/erro_rx/dado are valid combinationally in the stop-sample cycle.
module rx_serial_7O1
    import sonar_frame_rx_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       serial,
    output logic [6:0] dado,
    output logic       pronto_rx,
    output logic       erro_rx
);

    localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);

    rx_state_t        st, st_next;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [6:0]       shift;
    logic             par_bit;
    logic             serial_dly;
    logic             tick;

    // Sample point: half a bit into the start bit, then one full bit apart
    assign tick = (st == RX_START) ? (cnt == HALF_LAST) : (cnt == FULL_LAST);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) st <= RX_IDLE;
        else       st <= st_next;
    end

    // Next-state logic; a high line at the start midpoint is a false start
    always_comb begin
        st_next = st;
        case (st)
            RX_IDLE:   if (serial_dly && !serial) st_next = RX_START;
            RX_START:  if (tick) st_next = serial ? RX_IDLE : RX_DATA;
            RX_DATA:   if (tick && bit_idx == 3'd6) st_next = RX_PARITY;
            RX_PARITY: if (tick) st_next = RX_STOP;
            RX_STOP:   if (tick) st_next = RX_IDLE;
            default:   st_next = RX_IDLE;
        endcase
    end

    // Outputs: character done at the stop sample; bad on parity or framing error
    always_comb begin
        dado      = shift;
        pronto_rx = (st == RX_STOP) && tick;
        erro_rx   = pronto_rx && (!(^{shift, par_bit}) || !serial);
    end

    // Bit timing counter, shift register and edge-detect history
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            serial_dly <= 1'b1;
        end else begin
            serial_dly <= serial;
            if (st == RX_IDLE || tick) cnt <= '0;
            else                       cnt <= cnt + CNT_W'(1);
            if (st == RX_IDLE) bit_idx <= '0;
            if (st == RX_DATA && tick) begin
                shift   <= {serial, shift[6:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            if (st == RX_PARITY && tick) par_bit <= serial;
        end
    end

endmodule

// File: rtl/sonar_frame_rx.sv
// Sonar frame receiver: parses "DDD,DDD#" frames of 7O1 characters into
// BCD angle and distance, with error pulse and resynchronisation on '#'.
module sonar_frame_rx
    import sonar_frame_rx_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        entrada_serial,
    output logic [11:0] angulo,
    output logic [11:0] distancia,
    output logic        pronto,
    output logic        erro,
    output logic [3:0]  db_estado
);

    logic          entrada_p0, entrada_p1;
    logic [6:0]    dado;
    logic          pronto_rx, erro_rx;
    parser_state_t estado, estado_next;
    logic          char_good, is_hash, expected;
    logic          ok_pulse, err_pulse, wr_digit;
    logic [11:0]   sh_ang, sh_dist;

    // Two-flop synchronizer for the asynchronous serial line (idles high)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            entrada_p0 <= 1'b1;
            entrada_p1 <= 1'b1;
        end else begin
            entrada_p0 <= entrada_serial;
            entrada_p1 <= entrada_p0;
        end
    end

    rx_serial_7O1 #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx (
        .clock     (clock),
        .reset     (reset),
        .serial    (entrada_p1),
        .dado      (dado),
        .pronto_rx (pronto_rx),
        .erro_rx   (erro_rx)
    );

    // Character classification against what the current position expects
    always_comb begin
        char_good = pronto_rx && !erro_rx;
        is_hash   = (dado == ASCII_HASH);
        case (estado)
            ST_A2, ST_A1, ST_A0,
            ST_D2, ST_D1, ST_D0: expected = is_digit(dado);
            ST_VIRG:             expected = (dado == ASCII_VIRGULA);
            ST_FIM:              expected = is_hash;
            default:             expected = 1'b0;
        endcase
    end

    // Parser state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= ST_A2;
        else       estado <= estado_next;
    end

    // Parser next state: advance on expected, '#' restarts, anything else resyncs
    always_comb begin
        estado_next = estado;
        if (pronto_rx) begin
            if (estado == ST_RESYNC) begin
                if (char_good && is_hash) estado_next = ST_A2;
            end else if (!char_good) begin
                estado_next = ST_RESYNC;
            end else if (expected) begin
                case (estado)
                    ST_A2:   estado_next = ST_A1;
                    ST_A1:   estado_next = ST_A0;
                    ST_A0:   estado_next = ST_VIRG;
                    ST_VIRG: estado_next = ST_D2;
                    ST_D2:   estado_next = ST_D1;
                    ST_D1:   estado_next = ST_D0;
                    ST_D0:   estado_next = ST_FIM;
                    default: estado_next = ST_A2;
                endcase
            end else if (is_hash) begin
                estado_next = ST_A2;
            end else begin
                estado_next = ST_RESYNC;
            end
        end
    end

    // Parser outputs: frame commit, single error pulse, digit capture enable
    always_comb begin
        ok_pulse  = char_good && (estado == ST_FIM) && is_hash;
        err_pulse = pronto_rx && (estado != ST_RESYNC) && !(char_good && expected);
        wr_digit  = char_good && expected && (estado != ST_VIRG) && (estado != ST_FIM);
        db_estado = estado;
    end

    // Shadow digit capture and output registers; outputs change only on a full frame
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sh_ang    <= '0;
            sh_dist   <= '0;
            angulo    <= '0;
            distancia <= '0;
            pronto    <= 1'b0;
            erro      <= 1'b0;
        end else begin
            if (wr_digit) begin
                case (estado)
                    ST_A2:   sh_ang[11:8]  <= dado[3:0];
                    ST_A1:   sh_ang[7:4]   <= dado[3:0];
                    ST_A0:   sh_ang[3:0]   <= dado[3:0];
                    ST_D2:   sh_dist[11:8] <= dado[3:0];
                    ST_D1:   sh_dist[7:4]  <= dado[3:0];
                    ST_D0:   sh_dist[3:0]  <= dado[3:0];
                    default: ;
                endcase
            end
            pronto <= ok_pulse;
            erro   <= err_pulse;
            if (ok_pulse) begin
                angulo    <= sh_ang;
                distancia <= sh_dist;
            end
        end
    end

endmodule

// File: tb/tb_sonar_frame_rx.sv
// Bench for sonar_frame_rx: serial driver, frame-level reference model, one compare process.
module tb_sonar_frame_rx;

    localparam int BAUD = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        entrada_serial = 1'b1;
    logic [11:0] angulo, distancia;
    logic        pronto, erro;
    logic [3:0]  db_estado;

    sonar_frame_rx #(.BAUD_DIV(BAUD)) dut (
        .clock          (clock),
        .reset          (reset),
        .entrada_serial (entrada_serial),
        .angulo         (angulo),
        .distancia      (distancia),
        .pronto         (pronto),
        .erro           (erro),
        .db_estado      (db_estado)
    );

    always #5 clock = ~clock;

    // Reference model: position in "DDD,DDD#", resync flag, captured digits
    int          pos = 0;
    bit          resync = 0;
    logic [3:0]  dg [0:5];
    int          exp_pr = 0, exp_er = 0;
    logic [11:0] exp_ang = '0, exp_dist = '0;

    // Compare-process bookkeeping
    int          n_cmp = 0, n_fail = 0;
    int          pr_cnt = 0, er_cnt = 0;
    int          chk_sel = 0;
    bit          lit_en = 0;
    logic [11:0] lit_ang = '0, lit_dist = '0;
    int          exp_db = 0;

    function automatic bit slot_ok(input int p, input logic [7:0] c);
        if (p == 3) return c == 8'h2C;
        if (p == 7) return c == 8'h23;
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    task automatic model_apply(input logic [7:0] c, input bit bad);
        if (resync) begin
            if (!bad && c == 8'h23) begin
                resync = 0;
                pos = 0;
            end
        end else if (bad) begin
            exp_er++;
            resync = 1;
            pos = 0;
        end else if (!slot_ok(pos, c)) begin
            exp_er++;
            if (c != 8'h23) resync = 1;
            pos = 0;
        end else if (pos == 7) begin
            exp_pr++;
            exp_ang  = {dg[0], dg[1], dg[2]};
            exp_dist = {dg[3], dg[4], dg[5]};
            pos = 0;
        end else begin
            if (pos < 3) dg[pos] = c[3:0];
            else if (pos > 3) dg[pos-1] = c[3:0];
            pos++;
        end
    endtask

    task automatic model_reset();
        pos = 0;
        resync = 0;
        exp_ang = '0;
        exp_dist = '0;
        for (int i = 0; i < 6; i++) dg[i] = '0;
    endtask

    task automatic send_bit(input bit b);
        entrada_serial = b;
        repeat (BAUD) @(negedge clock);
    endtask

    task automatic send_char(input logic [7:0] c, input bit bad);
        logic par;
        par = ~(^c[6:0]) ^ bad;
        model_apply(c, bad);
        send_bit(1'b0);
        for (int i = 0; i < 7; i++) send_bit(c[i]);
        send_bit(par);
        send_bit(1'b1);
    endtask

    task automatic send_str(input string s, input int flip_idx, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            send_char(s[i], i == flip_idx);
            repeat (gap) @(negedge clock);
        end
    endtask

    // Hand a check request to the compare process for exactly one negedge
    task automatic trigger(input int sel);
        #1 chk_sel = sel;
        @(negedge clock);
        #1 chk_sel = 0;
    endtask

    task automatic frame_check(input bit le, input logic [11:0] a, input logic [11:0] d);
        repeat (4) @(negedge clock);
        lit_en = le;
        lit_ang = a;
        lit_dist = d;
        trigger(1);
    endtask

    task automatic db_check(input int v);
        exp_db = v;
        trigger(3);
    endtask

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Compare process: requested checks plus per-cycle pulse checks
    always @(negedge clock) begin
        case (chk_sel)
            1: begin
                chk("pronto_count", pr_cnt, exp_pr);
                chk("erro_count", er_cnt, exp_er);
                chk("angulo_model", angulo, exp_ang);
                chk("distancia_model", distancia, exp_dist);
                if (lit_en) begin
                    chk("angulo_literal", angulo, lit_ang);
                    chk("distancia_literal", distancia, lit_dist);
                end
            end
            2: begin
                chk("reset_angulo", angulo, 0);
                chk("reset_distancia", distancia, 0);
                chk("reset_pronto", pronto, 0);
                chk("reset_erro", erro, 0);
                chk("reset_db_estado", db_estado, 0);
            end
            3: chk("db_estado", db_estado, exp_db);
            default: ;
        endcase
        if (!reset) begin
            if (pronto || erro) chk("pulse_exclusive", int'(pronto && erro), 0);
            if (pronto) begin
                pr_cnt++;
                chk("angulo_at_pronto", angulo, exp_ang);
                chk("distancia_at_pronto", distancia, exp_dist);
            end
            if (erro) er_cnt++;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c5;
        model_reset();
        repeat (3) @(negedge clock);
        trigger(2);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Back-to-back valid frame
        send_str("045,123#", -1, 0);
        frame_check(1, 12'h045, 12'h123);

        // Letter in distance field: one error, '#' ends resync without pronto
        send_str("090,0A", -1, 2);
        db_check(8);
        send_str("7#", -1, 2);
        frame_check(1, 12'h045, 12'h123);
        send_str("180,200#", -1, 2);
        frame_check(1, 12'h180, 12'h200);

        // Parity error on second character
        send_str("010,050#", 1, 2);
        frame_check(1, 12'h180, 12'h200);
        send_str("246,135#", -1, 2);
        frame_check(1, 12'h246, 12'h135);

        // Early '#' restarts directly
        send_str("12", -1, 2);
        db_check(2);
        send_str("#", -1, 2);
        frame_check(1, 12'h246, 12'h135);
        db_check(0);
        send_str("007,999#", -1, 0);
        frame_check(1, 12'h007, 12'h999);

        // Two-cycle glitch on idle line
        entrada_serial = 1'b0;
        repeat (2) @(negedge clock);
        entrada_serial = 1'b1;
        repeat (20) @(negedge clock);
        frame_check(1, 12'h007, 12'h999);
        db_check(0);

        // Reset during bit 4 of the third character
        send_str("04", -1, 0);
        c5 = 8'h35;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(c5[i]);
        entrada_serial = c5[4];
        repeat (3) @(negedge clock);
        reset = 1'b1;
        entrada_serial = 1'b1;
        model_reset();
        repeat (2) @(negedge clock);
        trigger(2);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        send_str("321,654#", -1, 1);
        frame_check(1, 12'h321, 12'h654);

        repeat (5) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sonar_frame_rx.md
SONAR_FRAME_RX -- requirements
Module: sonar_frame_rx

Interface
REQ-001 Parameter: BAUD_DIV, default 434, clock cycles per serial bit (50 MHz / 115200).
REQ-002 Port: clock  in  1  single system clock; all state on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: entrada_serial  in  1  asynchronous serial line, idle high, 7O1 format.
REQ-005 Port: angulo  out  12  last valid angle, 3 BCD digits, hundreds in [11:8].
REQ-006 Port: distancia  out  12  last valid distance, 3 BCD digits, hundreds in [11:8].
REQ-007 Port: pronto  out  1  one-cycle pulse; angulo/distancia just updated.
REQ-008 Port: erro  out  1  one-cycle pulse; character or frame error detected.
REQ-009 Port: db_estado  out  4  current parser state encoding, debug only.

Function
REQ-010 entrada_serial SHALL pass through a 2-flop synchronizer before any use.
REQ-011 Character format SHALL be: start 0, 7 data bits LSB first, odd parity bit (ones in data+parity odd), stop 1.
REQ-012 Receiver SHALL start on a synchronized high-to-low edge, recheck the line at BAUD_DIV/2 cycles, and return to idle without error if high (false start).
REQ-013 Each later bit SHALL be sampled every BAUD_DIV cycles after the start-bit midpoint.
REQ-014 Parity mismatch or stop bit sampled 0 SHALL mark the character as bad; receiver SHALL return to idle after the stop sample regardless.
REQ-015 Frame SHALL be exactly 8 characters: D,D,D,',',D,D,D,'#'; D is 0x30-0x39, ',' is 0x2C, '#' is 0x23.
REQ-016 Parser states: A2,A1,A0,VIRG,D2,D1,D0,FIM,RESYNC; reset state A2.
REQ-017 Each good expected character SHALL advance one state. Digits SHALL be stored as low nibble in shadow registers.
REQ-018 In FIM, a good '#' SHALL copy shadow registers to angulo/distancia, pulse pronto, and go to A2.
REQ-019 Bad character, or unexpected character in any state A2-FIM, SHALL pulse erro once and go to RESYNC.
REQ-020 Exception: '#' received in A2-D0 SHALL pulse erro and go directly to A2.
REQ-021 In RESYNC, characters SHALL be discarded without further erro until a good '#', then the state SHALL go to A2.
REQ-022 pronto/erro latency: asserted the cycle after the stop-bit sample of the deciding character.
REQ-023 pronto and erro SHALL never assert in the same cycle.
REQ-024 angulo/distancia SHALL hold their value between valid frames; partial frames never alter them.
REQ-025 A start edge during the stop-bit interval SHALL be accepted only after the stop sample (back-to-back characters supported).

Reset
REQ-026 On reset: angulo=0, distancia=0, pronto=0, erro=0, parser in A2, receiver idle, shadow registers 0, synchronizer flops 1.
REQ-027 Reset asserted mid-character or mid-frame SHALL discard all partial data. The first character after release SHALL be treated as frame start.

Structure
REQ-028 Shared package SHALL hold ASCII_VIRGULA (0x2C), ASCII_HASH (0x23), ASCII_ZERO (0x30), parser state encodings, and BAUD_DIV default.
REQ-029 Character reception SHALL be one sub-module, rx_serial_7O1, with outputs dado[6:0], pronto_rx (pulse), and erro_rx.
REQ-030 Parser FSM and output registers SHALL be in sonar_frame_rx.

Verification (BAUD_DIV=8)
REQ-031 Send "045,123#" -> one pronto; angulo=0x045, distancia=0x123; erro never high.
REQ-032 Send "090,0A7#" (0x41 at D1) -> erro once on 'A'; no pronto on that '#'. Then send "180,200#" -> pronto; angulo=0x180, distancia=0x200.
REQ-033 Send '1' with parity bit flipped inside "010,050#" -> erro once; outputs unchanged; next valid frame accepted.
REQ-034 Send "12#" -> erro on '#'; immediately send "007,999#" -> pronto; angulo=0x007, distancia=0x999.
REQ-035 Send a 2-cycle low glitch on an idle line -> no character, no erro. Then send reset mid-frame at bit 4 of the 3rd character -> outputs 0; next full frame accepted.
